// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// a registered read port with valid strobe, and overflow/underflow error pulses.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  Empty,
    output logic                  Full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // with equal low bits; their difference is the occupancy directly.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                     (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);

    // Handshake: a write is accepted on any edge where we && !Full, a read on
    // any edge where re && !Empty, both judged on pre-edge flags and each
    // independently; rejected requests raise the matching error pulse instead.
    assign w_wr_en = we && !w_full;
    assign w_rd_en = re && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rptr     <= r_rptr + 1'b1;
                r_data_out <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
            end
            r_valid_out <= w_rd_en;
            r_overflow  <= we && w_full;
            r_underflow <= re && w_empty;
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign Empty        = w_empty;
    assign Full         = w_full;
    assign count        = w_count;
    assign almost_empty = (w_count <= LP_AEMPTY);
    assign almost_full  = (w_count >= LP_AFULL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: default 8x32 instance plus a 16x8 instance, both
// checked against queue-based reference models with randomized traffic.
module tb_sync_fifo_param;

    localparam int A_DW = 32, A_AW = 3, A_DEPTH = 8,  A_AF = 6,  A_AE = 2;
    localparam int B_DW = 8,  B_AW = 4, B_DEPTH = 16, B_AF = 15, B_AE = 1;

    logic clk;
    logic rst;

    logic              we_a, re_a;
    logic [A_DW-1:0]   din_a, dout_a;
    logic              valid_a, empty_a, full_a, ae_a, af_a, ovf_a, udf_a;
    logic [A_AW:0]     count_a;

    logic              we_b, re_b;
    logic [B_DW-1:0]   din_b, dout_b;
    logic              valid_b, empty_b, full_b, ae_b, af_b, ovf_b, udf_b;
    logic [B_AW:0]     count_b;

    int n_checks = 0;
    int n_errors = 0;
    string phase = "init";

    logic [A_DW-1:0] exp_qa[$];
    logic [A_DW-1:0] exp_dout_a;
    logic            exp_valid_a, exp_ovf_a, exp_udf_a;
    logic [B_DW-1:0] exp_qb[$];
    logic [B_DW-1:0] exp_dout_b;
    logic            exp_valid_b, exp_ovf_b, exp_udf_b;

    sync_fifo_param #(
        .DATA_WIDTH(A_DW), .ADDR_WIDTH(A_AW), .AFULL_THRESH(A_AF), .AEMPTY_THRESH(A_AE)
    ) u_dut_a (
        .clk(clk), .rst(rst), .we(we_a), .data_in(din_a), .re(re_a),
        .data_out(dout_a), .valid_out(valid_a), .Empty(empty_a), .Full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .count(count_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    sync_fifo_param #(
        .DATA_WIDTH(B_DW), .ADDR_WIDTH(B_AW), .AFULL_THRESH(B_AF), .AEMPTY_THRESH(B_AE)
    ) u_dut_b (
        .clk(clk), .rst(rst), .we(we_b), .data_in(din_b), .re(re_b),
        .data_out(dout_b), .valid_out(valid_b), .Empty(empty_b), .Full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .count(count_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s/%s: observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
        end
    endtask

    // Scoreboard comparisons: flags come from the model's occupancy alone.
    task automatic check_a();
        int n;
        n = exp_qa.size();
        chk("a_count",     32'(count_a),  32'(n));
        chk("a_empty",     32'(empty_a),  32'(n == 0));
        chk("a_full",      32'(full_a),   32'(n == A_DEPTH));
        chk("a_aempty",    32'(ae_a),     32'(n <= A_AE));
        chk("a_afull",     32'(af_a),     32'(n >= A_AF));
        chk("a_valid",     32'(valid_a),  32'(exp_valid_a));
        chk("a_data_out",  32'(dout_a),   32'(exp_dout_a));
        chk("a_overflow",  32'(ovf_a),    32'(exp_ovf_a));
        chk("a_underflow", 32'(udf_a),    32'(exp_udf_a));
    endtask

    task automatic check_b();
        int n;
        n = exp_qb.size();
        chk("b_count",     32'(count_b),  32'(n));
        chk("b_empty",     32'(empty_b),  32'(n == 0));
        chk("b_full",      32'(full_b),   32'(n == B_DEPTH));
        chk("b_aempty",    32'(ae_b),     32'(n <= B_AE));
        chk("b_afull",     32'(af_b),     32'(n >= B_AF));
        chk("b_valid",     32'(valid_b),  32'(exp_valid_b));
        chk("b_data_out",  32'(dout_b),   32'(exp_dout_b));
        chk("b_overflow",  32'(ovf_b),    32'(exp_ovf_b));
        chk("b_underflow", 32'(udf_b),    32'(exp_udf_b));
    endtask

    task automatic model_reset();
        exp_qa.delete();
        exp_qb.delete();
        exp_dout_a = '0; exp_valid_a = 1'b0; exp_ovf_a = 1'b0; exp_udf_a = 1'b0;
        exp_dout_b = '0; exp_valid_b = 1'b0; exp_ovf_b = 1'b0; exp_udf_b = 1'b0;
    endtask

    // Driver: one clock of instance A, then model update and full check.
    task automatic step_a(input logic w, input logic r, input logic [A_DW-1:0] d);
        bit pre_full, pre_empty;
        pre_full  = (exp_qa.size() == A_DEPTH);
        pre_empty = (exp_qa.size() == 0);
        we_a = w; re_a = r; din_a = d;
        @(posedge clk);
        #1;
        exp_ovf_a = w && pre_full;
        exp_udf_a = r && pre_empty;
        exp_valid_a = 1'b0;
        if (r && !pre_empty) begin
            exp_dout_a  = exp_qa.pop_front();
            exp_valid_a = 1'b1;
        end
        if (w && !pre_full) exp_qa.push_back(d);
        we_a = 1'b0; re_a = 1'b0;
        check_a();
    endtask

    task automatic step_b(input logic w, input logic r, input logic [B_DW-1:0] d);
        bit pre_full, pre_empty;
        pre_full  = (exp_qb.size() == B_DEPTH);
        pre_empty = (exp_qb.size() == 0);
        we_b = w; re_b = r; din_b = d;
        @(posedge clk);
        #1;
        exp_ovf_b = w && pre_full;
        exp_udf_b = r && pre_empty;
        exp_valid_b = 1'b0;
        if (r && !pre_empty) begin
            exp_dout_b  = exp_qb.pop_front();
            exp_valid_b = 1'b1;
        end
        if (w && !pre_full) exp_qb.push_back(d);
        we_b = 1'b0; re_b = 1'b0;
        check_b();
    endtask

    initial begin
        logic [A_DW-1:0] data_ctr;
        rst = 1'b1;
        we_a = 1'b0; re_a = 1'b0; din_a = '0;
        we_b = 1'b0; re_b = 1'b0; din_b = '0;
        model_reset();

        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_a();
        check_b();
        rst = 1'b0;

        phase = "fill";
        for (int i = 1; i <= 8; i++) step_a(1'b1, 1'b0, 32'(i));
        step_a(1'b1, 1'b0, 32'hDEADBEEF);
        step_a(1'b0, 1'b0, '0);

        phase = "drain";
        for (int i = 0; i < 8; i++) step_a(1'b0, 1'b1, '0);
        step_a(1'b0, 1'b1, '0);
        step_a(1'b0, 1'b0, '0);

        phase = "wrap";
        data_ctr = 32'h100;
        for (int burst = 0; burst < 4; burst++) begin
            for (int i = 0; i < 5; i++) begin
                step_a(1'b1, 1'b0, data_ctr);
                data_ctr++;
            end
            for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, '0);
        end

        phase = "simul_rw";
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 10; i++) step_a(1'b1, 1'b1, 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, $urandom);
        step_a(1'b1, 1'b1, 32'h0BAD0BAD);
        for (int i = 0; i < 7; i++) step_a(1'b0, 1'b1, '0);
        step_a(1'b1, 1'b1, 32'h600DF00D);
        step_a(1'b0, 1'b1, '0);

        phase = "mid_reset";
        for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0, $urandom);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_a();
        #2 rst = 1'b0;
        step_a(1'b0, 1'b1, '0);
        step_a(1'b1, 1'b0, 32'h12345678);
        step_a(1'b0, 1'b1, '0);

        phase = "random_a";
        for (int i = 0; i < 200; i++)
            step_a($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom);

        phase = "b_fill";
        for (int i = 0; i < 17; i++) step_b(1'b1, 1'b0, 8'($urandom));
        phase = "b_drain";
        for (int i = 0; i < 17; i++) step_b(1'b0, 1'b1, '0);
        phase = "random_b";
        for (int i = 0; i < 400; i++)
            step_b($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 48, 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
